// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one word-wide memory port between Icache refills
// and Dcache refills/writebacks, sequencing one LINE_WORDS-beat burst per grant.
module mem_port_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic [IDX_W-1:0]  i_idx_o,
  output logic              i_done_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [IDX_W-1:0]  d_idx_o,
  output logic              d_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  localparam int                OFF_W    = IDX_W + 2;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic              last_d_q, last_d_d;

  logic busy_i, busy_d, busy, wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      we_q     <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      we_q     <= we_d;
      last_d_q <= last_d_d;
    end
  end

  // last_d_q doubles as "who owns the current burst" from grant through DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    we_d     = we_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (d_req_i && (!i_req_i || !last_d_q)) begin
          state_d  = BUSY_D;
          base_d   = d_addr_i & ~OFF_MASK;
          we_d     = d_we_i;
          last_d_d = 1'b1;
          cnt_d    = '0;
        end else if (i_req_i) begin
          state_d  = BUSY_I;
          base_d   = i_addr_i & ~OFF_MASK;
          we_d     = 1'b0;
          last_d_d = 1'b0;
          cnt_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready_i) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_i = (state_q == BUSY_I);
  assign busy_d = (state_q == BUSY_D);
  assign busy   = busy_i | busy_d;
  assign wr_d   = busy_d & we_q;

  assign mem_req_o   = busy;
  assign mem_we_o    = wr_d;
  assign mem_addr_o  = busy ? (base_q | (ADDR_W'(cnt_q) << 2)) : '0;
  assign mem_wdata_o = wr_d ? d_wdata_i : '0;

  assign i_rvalid_o = busy_i & mem_ready_i;
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
  assign i_idx_o    = busy_i ? cnt_q : '0;
  assign i_done_o   = (state_q == DONE) & ~last_d_q;

  assign d_rvalid_o = busy_d & mem_ready_i & ~we_q;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;
  assign d_idx_o    = busy_d ? cnt_q : '0;
  assign d_done_o   = (state_q == DONE) & last_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: a cycle-by-cycle vector table
// plus hand-written sequences for simultaneous requests and mid-burst reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        iReq, dReq, dWe, memReady;
  logic [31:0] iAddr, dAddr, dWdata, memRdata;
  logic        iRvalid, iDone, dRvalid, dDone, memReq, memWe;
  logic [31:0] iRdata, dRdata, memAddr, memWdata;
  logic [1:0]  iIdx, dIdx;

  int nChecks = 0;
  int nErrors = 0;
  int iDonePulses = 0;

  typedef struct {
    string       name;
    logic        iq, dq, we;
    logic [31:0] ia, da;
    logic        rdy;
    logic        eReq, eWe;
    logic [31:0] eAddr, eWdata;
    logic        eIRv;
    logic [1:0]  eIIdx;
    logic        eIDone, eDRv;
    logic [1:0]  eDIdx;
    logic        eDDone;
  } vec_t;

  vec_t vecs[32];

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rstN),
    .i_req_i(iReq), .i_addr_i(iAddr), .i_rvalid_o(iRvalid), .i_rdata_o(iRdata),
    .i_idx_o(iIdx), .i_done_o(iDone),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata),
    .d_rvalid_o(dRvalid), .d_rdata_o(dRdata), .d_idx_o(dIdx), .d_done_o(dDone),
    .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata), .mem_ready_i(memReady)
  );

  always #5 clk = ~clk;

  // Dcache model: writeback word for the index the arbiter is currently asking for.
  always_comb dWdata = 32'hA0 + {30'b0, dIdx};

  always @(posedge clk) if (iDone) iDonePulses <= iDonePulses + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int k);
    iReq     = v.iq;
    dReq     = v.dq;
    dWe      = v.we;
    iAddr    = v.ia;
    dAddr    = v.da;
    memReady = v.rdy;
    memRdata = 32'hC000 + k;
  endtask

  task automatic checkVector(input vec_t v, input int k);
    logic [31:0] rd;
    rd = 32'hC000 + k;
    checkOutput({v.name, ".mem_req"},   {31'b0, memReq},  {31'b0, v.eReq});
    checkOutput({v.name, ".mem_we"},    {31'b0, memWe},   {31'b0, v.eWe});
    checkOutput({v.name, ".mem_addr"},  memAddr,          v.eAddr);
    checkOutput({v.name, ".mem_wdata"}, memWdata,         v.eWdata);
    checkOutput({v.name, ".i_rvalid"},  {31'b0, iRvalid}, {31'b0, v.eIRv});
    checkOutput({v.name, ".i_rdata"},   iRdata,           v.eIRv ? rd : 32'h0);
    checkOutput({v.name, ".i_idx"},     {30'b0, iIdx},    {30'b0, v.eIIdx});
    checkOutput({v.name, ".i_done"},    {31'b0, iDone},   {31'b0, v.eIDone});
    checkOutput({v.name, ".d_rvalid"},  {31'b0, dRvalid}, {31'b0, v.eDRv});
    checkOutput({v.name, ".d_rdata"},   dRdata,           v.eDRv ? rd : 32'h0);
    checkOutput({v.name, ".d_idx"},     {30'b0, dIdx},    {30'b0, v.eDIdx});
    checkOutput({v.name, ".d_done"},    {31'b0, dDone},   {31'b0, v.eDDone});
  endtask

  task automatic doReset();
    rstN = 1'b0;
    iReq = 0; dReq = 0; dWe = 0; iAddr = 0; dAddr = 0; memReady = 0; memRdata = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst.mem_req",  {31'b0, memReq},  32'h0);
    checkOutput("rst.mem_addr", memAddr,          32'h0);
    checkOutput("rst.i_done",   {31'b0, iDone},   32'h0);
    checkOutput("rst.d_done",   {31'b0, dDone},   32'h0);
    rstN = 1'b1;
  endtask

  initial begin
    int          beatCyc[$];
    logic [31:0] beatAddr[$];
    int          dDoneCyc, iDoneCyc, snap;
    bit          dSeen, iSeen;
    logic [31:0] expAddr;

    // I refill of 0x104C, then DONE with ready still high, then idle ready pulses.
    vecs[0]  = '{"i_idle",   1,0,0,32'h104C,0,1,      0,0,32'h0,   0, 0,0,0, 0,0,0};
    vecs[1]  = '{"i_b0",     1,0,0,32'h104C,0,1,      1,0,32'h1040,0, 1,0,0, 0,0,0};
    vecs[2]  = '{"i_b1",     1,0,0,32'h104C,0,1,      1,0,32'h1044,0, 1,1,0, 0,0,0};
    vecs[3]  = '{"i_b2",     1,0,0,32'h104C,0,1,      1,0,32'h1048,0, 1,2,0, 0,0,0};
    vecs[4]  = '{"i_b3",     1,0,0,32'h104C,0,1,      1,0,32'h104C,0, 1,3,0, 0,0,0};
    vecs[5]  = '{"i_done",   1,0,0,32'h104C,0,1,      0,0,32'h0,   0, 0,0,1, 0,0,0};
    vecs[6]  = '{"idle_rdy", 0,0,0,0,0,1,             0,0,32'h0,   0, 0,0,0, 0,0,0};
    vecs[7]  = '{"idle_rdy2",0,0,0,0,0,1,             0,0,32'h0,   0, 0,0,0, 0,0,0};
    // D refill of 0x5008 with one stalled cycle; D then re-requests during its DONE.
    vecs[8]  = '{"d_grant",  0,1,0,0,32'h5008,0,      0,0,32'h0,   0, 0,0,0, 0,0,0};
    vecs[9]  = '{"d_wait",   0,1,0,0,32'h5008,0,      1,0,32'h5000,0, 0,0,0, 0,0,0};
    vecs[10] = '{"d_b0",     0,1,0,0,32'h5008,1,      1,0,32'h5000,0, 0,0,0, 1,0,0};
    vecs[11] = '{"d_b1",     0,1,0,0,32'h5008,1,      1,0,32'h5004,0, 0,0,0, 1,1,0};
    vecs[12] = '{"d_b2",     0,1,0,0,32'h5008,1,      1,0,32'h5008,0, 0,0,0, 1,2,0};
    vecs[13] = '{"d_b3",     0,1,0,0,32'h5008,1,      1,0,32'h500C,0, 0,0,0, 1,3,0};
    vecs[14] = '{"d_done",   1,1,0,32'h1000,32'h5008,1, 0,0,32'h0, 0, 0,0,0, 0,0,1};
    vecs[15] = '{"rr_idle",  1,1,0,32'h1000,32'h5008,1, 0,0,32'h0, 0, 0,0,0, 0,0,0};
    vecs[16] = '{"rr_i_b0",  1,1,0,32'h1000,32'h5008,1, 1,0,32'h1000,0, 1,0,0, 0,0,0};
    vecs[17] = '{"rr_i_b1",  1,1,0,32'h1000,32'h5008,1, 1,0,32'h1004,0, 1,1,0, 0,0,0};
    vecs[18] = '{"rr_i_b2",  1,1,0,32'h1000,32'h5008,1, 1,0,32'h1008,0, 1,2,0, 0,0,0};
    vecs[19] = '{"rr_i_b3",  1,1,0,32'h1000,32'h5008,1, 1,0,32'h100C,0, 1,3,0, 0,0,0};
    vecs[20] = '{"rr_i_done",1,1,0,32'h1000,32'h5008,1, 0,0,32'h0, 0, 0,0,1, 0,0,0};
    // D writeback of 0x2000, ready every other cycle; we/addr change mid-burst.
    vecs[21] = '{"wb_grant", 0,1,1,0,32'h2000,0,      0,0,32'h0,   0,     0,0,0, 0,0,0};
    vecs[22] = '{"wb0_wait", 0,1,1,0,32'h2000,0,      1,1,32'h2000,32'hA0, 0,0,0, 0,0,0};
    vecs[23] = '{"wb0",      0,1,1,0,32'h2000,1,      1,1,32'h2000,32'hA0, 0,0,0, 0,0,0};
    vecs[24] = '{"wb1_wait", 0,1,1,0,32'h2000,0,      1,1,32'h2004,32'hA1, 0,0,0, 0,1,0};
    vecs[25] = '{"wb1",      0,1,0,0,32'h9000,1,      1,1,32'h2004,32'hA1, 0,0,0, 0,1,0};
    vecs[26] = '{"wb2_wait", 0,1,0,0,32'h9000,0,      1,1,32'h2008,32'hA2, 0,0,0, 0,2,0};
    vecs[27] = '{"wb2",      0,1,0,0,32'h9000,1,      1,1,32'h2008,32'hA2, 0,0,0, 0,2,0};
    vecs[28] = '{"wb3_wait", 0,1,0,0,32'h9000,0,      1,1,32'h200C,32'hA3, 0,0,0, 0,3,0};
    vecs[29] = '{"wb3",      0,1,0,0,32'h9000,1,      1,1,32'h200C,32'hA3, 0,0,0, 0,3,0};
    vecs[30] = '{"wb_done",  0,1,0,0,32'h9000,0,      0,0,32'h0,   0,     0,0,0, 0,0,1};
    vecs[31] = '{"wb_idle",  0,0,0,0,0,0,             0,0,32'h0,   0,     0,0,0, 0,0,0};

    doReset();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      applyStimulus(vecs[k], k);
      #1;
      checkVector(vecs[k], k);
    end

    // Simultaneous requests after reset: D first, then I, with a 2-cycle gap.
    doReset();
    @(negedge clk);
    iReq = 1; dReq = 1; dWe = 0; iAddr = 32'h1000; dAddr = 32'h3000; memReady = 1;
    dSeen = 0; iSeen = 0; dDoneCyc = -1; iDoneCyc = -1;
    for (int c = 0; c < 40 && !iSeen; c++) begin
      #1;
      if (memReq && memReady) begin
        beatCyc.push_back(c);
        beatAddr.push_back(memAddr);
      end
      if (dDone) begin dSeen = 1; dDoneCyc = c; dReq = 0; end
      if (iDone) begin iSeen = 1; iDoneCyc = c; iReq = 0; end
      @(negedge clk);
    end
    checkOutput("both.d_done_seen", {31'b0, dSeen}, 32'h1);
    checkOutput("both.i_done_seen", {31'b0, iSeen}, 32'h1);
    checkOutput("both.beats", beatCyc.size(), 8);
    if (beatCyc.size() == 8) begin
      for (int b = 0; b < 8; b++) begin
        expAddr = (b < 4) ? 32'h3000 + 4 * b : 32'h1000 + 4 * (b - 4);
        checkOutput($sformatf("both.addr%0d", b), beatAddr[b], expAddr);
      end
      checkOutput("both.gap", beatCyc[4] - beatCyc[3] - 1, 2);
      checkOutput("both.d_done_cyc", dDoneCyc, beatCyc[3] + 1);
      checkOutput("both.i_done_cyc", iDoneCyc, beatCyc[7] + 1);
    end

    // Asynchronous reset in the middle of an I refill.
    doReset();
    snap = iDonePulses;
    @(negedge clk);
    iReq = 1; iAddr = 32'h1000; memReady = 1;
    @(negedge clk); #1;
    checkOutput("arst.beat0_idx", {30'b0, iIdx}, 32'h0);
    @(negedge clk); #1;
    checkOutput("arst.beat1_idx", {30'b0, iIdx}, 32'h1);
    @(posedge clk); #3;
    checkOutput("arst.pre_req", {31'b0, memReq}, 32'h1);
    checkOutput("arst.pre_idx", {30'b0, iIdx},   32'h2);
    rstN = 1'b0;
    #1;
    checkOutput("arst.req",    {31'b0, memReq},  32'h0);
    checkOutput("arst.idx",    {30'b0, iIdx},    32'h0);
    checkOutput("arst.rvalid", {31'b0, iRvalid}, 32'h0);
    checkOutput("arst.addr",   memAddr,          32'h0);
    repeat (2) @(negedge clk);
    dReq = 1; dWe = 0; dAddr = 32'h4000;
    rstN = 1'b1;
    @(negedge clk); #1;
    checkOutput("arst.d_req",   {31'b0, memReq}, 32'h1);
    checkOutput("arst.d_addr",  memAddr,         32'h4000);
    checkOutput("arst.d_idx",   {30'b0, dIdx},   32'h0);
    checkOutput("arst.i_idx",   {30'b0, iIdx},   32'h0);
    dSeen = 0;
    for (int c = 0; c < 12 && !dSeen; c++) begin
      @(negedge clk); #1;
      if (dDone) dSeen = 1;
    end
    checkOutput("arst.d_done_seen", {31'b0, dSeen}, 32'h1);
    checkOutput("arst.no_i_done", iDonePulses - snap, 0);
    dReq = 0; iReq = 0;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
